// File: rtl/vga_sync_receiver.sv
`default_nettype none
// vga_sync_receiver: recovers pixel phase and coordinates from a VGA sync stream and checks line/frame periods.
// Optional feature macro VGA_RX_CRC_EN adds a per-frame CRC-16-CCITT over the received pixels.
module vga_sync_receiver #(
  parameter int CLK_DIV     = 4,
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_TOTAL     = 800,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb_in,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        pixel_valid,
  output logic [11:0] pixel_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        frame_crc_valid
`endif
);

  localparam int LINE_CLKS = H_TOTAL * CLK_DIV;
  localparam int LOSS_CLKS = 2 * LINE_CLKS;
  // Wide enough to reach the sync-loss threshold, not just one line period.
  localparam int HPER_W    = $clog2(LOSS_CLKS + 1);
  localparam int PH_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ACQ_W     = $clog2(LOCK_FRAMES + 1);

  localparam logic [HPER_W-1:0] LINE_LAST  = HPER_W'(LINE_CLKS - 1);
  localparam logic [HPER_W-1:0] LOSS_LIMIT = HPER_W'(LOSS_CLKS);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_MID     = PH_W'(CLK_DIV / 2);
  localparam logic [9:0]        X_LOAD     = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]        X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]        X_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0]        Y_LOAD     = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]        Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]        Y_VIS      = 10'(V_VISIBLE);
  localparam logic [10:0]       LINES_EXP  = 11'(V_TOTAL);
  localparam logic [ACQ_W-1:0]  ACQ_LAST   = ACQ_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        hs_q, vs_q;
  logic [11:0]       rgb_s1_q, rgb_s2_q;
  logic [HPER_W-1:0] hper_q, hper_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [9:0]        rx_x_q, rx_x_d, rx_y_q, rx_y_d, lcnt_q, lcnt_d;
  logic [ACQ_W-1:0]  acq_q, acq_d;
  logic              hseen_q, hseen_d, vseen_q, vseen_d;
  logic              line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic              pixel_valid_q, pixel_valid_d, frame_start_q, frame_start_d;
  logic [11:0]       pixel_rgb_q, pixel_rgb_d;
  logic              hedge, vedge, is_locked;
  logic [10:0]       lcnt_incl;

  // Edges are taken between the second synchronizer stage and its delayed copy.
  assign hedge     = hs_q[2] & ~hs_q[1];
  assign vedge     = vs_q[2] & ~vs_q[1];
  assign is_locked = (state_q == ST_LOCKED);
  assign lcnt_incl = {1'b0, lcnt_q} + 11'(hedge);

  always_comb begin
    hper_d        = (hper_q == LOSS_LIMIT) ? hper_q : hper_q + HPER_W'(1);
    phase_d       = phase_q;
    rx_x_d        = rx_x_q;
    rx_y_d        = rx_y_q;
    lcnt_d        = lcnt_q;
    acq_d         = acq_q;
    hseen_d       = hseen_q;
    vseen_d       = vseen_q;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;
    state_d       = state_q;

    if (hedge) begin
      line_err_d = hseen_q && (hper_q != LINE_LAST);
      hseen_d    = 1'b1;
      hper_d     = '0;
      phase_d    = '0;
      rx_x_d     = X_LOAD;
      lcnt_d     = (lcnt_q == 10'h3FF) ? lcnt_q : lcnt_q + 10'd1;
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
      if (rx_x_q == X_LAST) begin
        rx_x_d = '0;
        rx_y_d = (rx_y_q == Y_LAST) ? 10'd0 : rx_y_q + 10'd1;
      end else begin
        rx_x_d = rx_x_q + 10'd1;
      end
    end else begin
      phase_d = phase_q + PH_W'(1);
    end

    // A coincident hSync edge is already counted in lcnt_incl.
    if (vedge) begin
      frame_err_d = vseen_q && (lcnt_incl != LINES_EXP);
      vseen_d     = 1'b1;
      lcnt_d      = '0;
      rx_y_d      = Y_LOAD;
    end

    case (state_q)
      ST_UNLOCKED: begin
        if (vedge) begin
          state_d = ST_ACQUIRE;
          acq_d   = '0;
        end
      end
      ST_ACQUIRE: begin
        if (vedge && !line_err_d && !frame_err_d) begin
          if (acq_q == ACQ_LAST) state_d = ST_LOCKED;
          else                   acq_d   = acq_q + ACQ_W'(1);
        end
      end
      ST_LOCKED: ;
      default: state_d = ST_UNLOCKED;
    endcase

    if ((state_q != ST_UNLOCKED) && (line_err_q || frame_err_q)) state_d = ST_UNLOCKED;
    if (hper_q == LOSS_LIMIT) state_d = ST_UNLOCKED;

    // The first period after losing lock is never judged.
    if ((state_d == ST_UNLOCKED) && (state_q != ST_UNLOCKED)) begin
      hseen_d = 1'b0;
      vseen_d = 1'b0;
    end

    pixel_valid_d = is_locked && (phase_q == PH_MID) && (rx_x_q < X_VIS) && (rx_y_q < Y_VIS);
    pixel_rgb_d   = pixel_valid_d ? rgb_s2_q : pixel_rgb_q;
    frame_start_d = is_locked && (rx_x_q == 10'd0) && (rx_y_q == 10'd0) && (phase_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q          <= '1;
      vs_q          <= '1;
      rgb_s1_q      <= '0;
      rgb_s2_q      <= '0;
      hper_q        <= '0;
      phase_q       <= '0;
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      lcnt_q        <= '0;
      acq_q         <= '0;
      hseen_q       <= 1'b0;
      vseen_q       <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_rgb_q   <= '0;
      frame_start_q <= 1'b0;
      state_q       <= ST_UNLOCKED;
    end else begin
      hs_q          <= {hs_q[1:0], hSync};
      vs_q          <= {vs_q[1:0], vSync};
      rgb_s1_q      <= rgb_in;
      rgb_s2_q      <= rgb_s1_q;
      hper_q        <= hper_d;
      phase_q       <= phase_d;
      rx_x_q        <= rx_x_d;
      rx_y_q        <= rx_y_d;
      lcnt_q        <= lcnt_d;
      acq_q         <= acq_d;
      hseen_q       <= hseen_d;
      vseen_q       <= vseen_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_rgb_q   <= pixel_rgb_d;
      frame_start_q <= frame_start_d;
      state_q       <= state_d;
    end
  end

  assign rx_x        = rx_x_q;
  assign rx_y        = rx_y_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign frame_start = frame_start_q;
  assign locked      = is_locked;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;
  logic        frame_crc_valid_q, frame_crc_valid_d;

  function automatic logic [15:0] crc12(input logic [15:0] c_in, input logic [11:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always_comb begin
    crc_d             = crc_q;
    if (frame_start_q)      crc_d = 16'hFFFF;
    else if (pixel_valid_q) crc_d = crc12(crc_q, pixel_rgb_q);
    frame_crc_valid_d = pixel_valid_q && (rx_x_q == X_VIS - 10'd1) && (rx_y_q == Y_VIS - 10'd1);
    frame_crc_d       = frame_crc_valid_d ? crc_d : frame_crc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q             <= 16'hFFFF;
      frame_crc_q       <= '0;
      frame_crc_valid_q <= 1'b0;
    end else begin
      crc_q             <= crc_d;
      frame_crc_q       <= frame_crc_d;
      frame_crc_valid_q <= frame_crc_valid_d;
    end
  end

  assign frame_crc       = frame_crc_q;
  assign frame_crc_valid = frame_crc_valid_q;
`endif

endmodule
`default_nettype wire
